// File: rtl/uart_rx_deframer.sv
// -----------------------------------------------------------------------------
// uart_rx_deframer
//
// Serial receive front end of the UART controller. The asynchronous srx line
// is synchronised, oversampled with a 16x baud enable tick and deframed into
// one 11-bit record per character:
//
//   record = {data[7:0], break, parity_err, framing_err}
//
// The record is accompanied by a single-cycle push strobe and feeds the
// receive FIFO directly.
//
// Ports:
//   clk           core clock
//   nreset        asynchronous active-low reset
//   enable        16x baud tick, one clk wide (may be held high)
//   srx           asynchronous serial input, idles high
//   rx_reset      synchronous abort/flush; same effect as nreset
//   data_bits     character length: 0=5, 1=6, 2=7, 3=8 bits
//   parity_en     parity bit present
//   parity_even   1=even parity, 0=odd parity
//   parity_stick  stick parity: expected parity bit is ~parity_even
//   record        {data[7:0], break, parity_err, framing_err}
//   push          record valid strobe, one clk wide
//   busy          receiver not in IDLE
//
// Build option:
//   UART_RX_MAJORITY_EN  when defined, every bit decision is the 2-of-3
//                        majority of srx_s captured at counter 14, 15 and 0
//                        (start check: 6, 7 and 8). When undefined, a single
//                        sample is used and the majority flops do not exist.
// -----------------------------------------------------------------------------
module uart_rx_deframer #(
  parameter int REC_WIDTH   = 11,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 enable,
  input  logic                 srx,
  input  logic                 rx_reset,
  input  logic [1:0]           data_bits,
  input  logic                 parity_en,
  input  logic                 parity_even,
  input  logic                 parity_stick,
  output logic [REC_WIDTH-1:0] record,
  output logic                 push,
  output logic                 busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_e;

  // Decision points within a bit. START_CHK_CNT is the counter value at which
  // the start bit is re-checked, BIT_CHK_CNT the value at which data, parity
  // and stop bits are decided. DATA_CNT_INIT is loaded on leaving START so the
  // first data decision lands exactly 16 ticks after the start check.
`ifdef UART_RX_MAJORITY_EN
  localparam logic [3:0] START_CHK_CNT = 4'd8;
  localparam logic [3:0] BIT_CHK_CNT   = 4'd0;
  localparam logic [3:0] DATA_CNT_INIT = 4'd1;
`else
  localparam logic [3:0] START_CHK_CNT = 4'd7;
  localparam logic [3:0] BIT_CHK_CNT   = 4'd15;
  localparam logic [3:0] DATA_CNT_INIT = 4'd0;
`endif

  // ---------------------------------------------------------------------------
  // Metastability synchroniser. Resets to the idle (high) line level so that
  // leaving reset never looks like a start bit.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   srx_s;

  // NOTE: sequential blocks use non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync_q <= '1;
    end else if (rx_reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], srx};
    end
  end

  assign srx_s = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Receiver state
  // ---------------------------------------------------------------------------
  state_e               state_q;
  logic [3:0]           cnt_q;       // 16x oversampling tick counter
  logic [2:0]           bit_idx_q;   // next data bit position
  logic [7:0]           data_q;      // received data, LSB first
  logic                 par_bit_q;   // raw parity sample (break detection)
  logic                 par_err_q;   // parity mismatch for current frame
  logic [REC_WIDTH-1:0] record_q;
  logic                 push_q;
  logic                 busy_q;

  // ---------------------------------------------------------------------------
  // Bit decision value: a single sample, or a 2-of-3 vote over three
  // consecutive ticks centred on mid-bit.
  // ---------------------------------------------------------------------------
  logic bit_val;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] maj_q;

  // The low three counter bits match 6/7 at both the start check (6, 7) and
  // mid-bit (14, 15); captures at the off-window value are overwritten before
  // the next decision, so one comparison serves both windows.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      maj_q <= '1;
    end else if (rx_reset) begin
      maj_q <= '1;
    end else if (enable) begin
      if (cnt_q[2:0] == 3'd6) maj_q[0] <= srx_s;
      if (cnt_q[2:0] == 3'd7) maj_q[1] <= srx_s;
    end
  end

  assign bit_val = (maj_q[0] & maj_q[1]) |
                   (maj_q[0] & srx_s)    |
                   (maj_q[1] & srx_s);
`else
  assign bit_val = srx_s;
`endif

  // ---------------------------------------------------------------------------
  // Frame-level combinational helpers
  // ---------------------------------------------------------------------------
  logic [2:0] last_idx;     // index of the last data bit (N-1)
  logic       par_exp;      // expected parity bit value
  logic       par_err_flag; // parity error as reported in the record
  logic       brk;          // break condition at the stop decision

  // NOTE: every signal written in always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    last_idx     = 3'd4 + {1'b0, data_bits};
    par_exp      = 1'b0;
    if (parity_stick) begin
      par_exp = ~parity_even;
    end else if (parity_even) begin
      par_exp = ^data_q;
    end else begin
      par_exp = ~(^data_q);
    end
    par_err_flag = par_err_q & parity_en;
    // Bits beyond the character length are held at zero, so comparing the
    // whole shift register covers every received data bit.
    brk          = ~bit_val && (data_q == 8'h00) && (!parity_en || !par_bit_q);
  end

  // ---------------------------------------------------------------------------
  // Receive FSM. State and counters advance only on enable ticks; the push
  // strobe is cleared on every clk so it stays exactly one clk wide.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      par_bit_q <= 1'b0;
      par_err_q <= 1'b0;
      record_q  <= '0;
      push_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else if (rx_reset) begin
      // Abort: any frame in progress is dropped without a push.
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      par_bit_q <= 1'b0;
      par_err_q <= 1'b0;
      record_q  <= '0;
      push_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (enable) begin
        cnt_q <= cnt_q + 4'd1;
        case (state_q)
          IDLE: begin
            cnt_q <= '0;
            if (!srx_s) begin
              state_q <= START;
              busy_q  <= 1'b1;
            end
          end

          START: begin
            if (cnt_q == START_CHK_CNT) begin
              if (bit_val) begin
                // Line is high again at mid start bit: a glitch, not a frame.
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end else begin
                state_q   <= DATA;
                cnt_q     <= DATA_CNT_INIT;
                bit_idx_q <= '0;
                data_q    <= '0;
                par_bit_q <= 1'b0;
                par_err_q <= 1'b0;
              end
            end
          end

          DATA: begin
            if (cnt_q == BIT_CHK_CNT) begin
              data_q[bit_idx_q] <= bit_val;
              bit_idx_q         <= bit_idx_q + 3'd1;
              // '>=' rather than '==' so a character length shortened
              // mid-frame still terminates the data phase.
              if (bit_idx_q >= last_idx) begin
                state_q <= parity_en ? PARITY : STOP;
              end
            end
          end

          PARITY: begin
            if (cnt_q == BIT_CHK_CNT) begin
              par_bit_q <= bit_val;
              par_err_q <= (bit_val != par_exp);
              state_q   <= STOP;
            end
          end

          STOP: begin
            if (cnt_q == BIT_CHK_CNT) begin
              push_q <= 1'b1;
              if (brk) begin
                record_q <= {8'h00, 1'b1, par_err_flag, 1'b1};
                state_q  <= WAIT_IDLE;
              end else begin
                // Leaving at mid-stop lets a back-to-back start bit be seen.
                record_q <= {data_q, 1'b0, par_err_flag, ~bit_val};
                state_q  <= IDLE;
                busy_q   <= 1'b0;
              end
            end
          end

          WAIT_IDLE: begin
            // Line held low after a break: stay silent until it returns high.
            if (srx_s) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end

          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign record = record_q;
  assign push   = push_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_deframer
//
// Self-checking bench for uart_rx_deframer. A table of frame vectors (config,
// payload, parity bit, stop bit, expected record) is driven onto srx with a
// 16x enable every 4th clk. Expected records are queued when a frame is
// driven; a monitor collects every pushed record and the main sequence pops
// and compares them. Hand-written sequences cover reset, break, glitch,
// rx_reset and nreset mid-frame.
// -----------------------------------------------------------------------------
module tb_uart_rx_deframer;

  logic        clk = 1'b0;
  logic        nreset;
  logic        enable;
  logic        srx;
  logic        rx_reset;
  logic [1:0]  data_bits;
  logic        parity_en;
  logic        parity_even;
  logic        parity_stick;
  logic [10:0] record;
  logic        push;
  logic        busy;

  uart_rx_deframer dut (
    .clk          (clk),
    .nreset       (nreset),
    .enable       (enable),
    .srx          (srx),
    .rx_reset     (rx_reset),
    .data_bits    (data_bits),
    .parity_en    (parity_en),
    .parity_even  (parity_even),
    .parity_stick (parity_stick),
    .record       (record),
    .push         (push),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // 16x baud tick: one clk in four, changed on the falling edge.
  int div = 0;
  initial begin
    enable = 1'b0;
    forever begin
      @(negedge clk);
      div    = (div + 1) % 4;
      enable = (div == 0);
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int          n_vec    = 0;
  int          n_err    = 0;
  int          push_cnt = 0;
  int          obs_rd   = 0;
  logic [10:0] exp_q[$];
  logic [10:0] obs_q[$];

  always @(negedge clk) begin
    if (nreset && push) begin
      obs_q.push_back(record);
      push_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Compare all queued expectations against records pushed since 'base'.
  task automatic score(input string name, input int base, input int n_exp);
    logic [10:0] e;
    check({name, "_pushes"}, push_cnt - base, n_exp);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (obs_rd < push_cnt) begin
        check(name, {21'd0, obs_q[obs_rd]}, {21'd0, e});
        obs_rd++;
      end else begin
        n_vec++;
        n_err++;
        $display("FAIL %s: no record pushed, expected %0h", name, e);
      end
    end
    obs_rd = push_cnt;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!enable) @(posedge clk);
    end
    #1;
  endtask

  task automatic send_bit(input logic b);
    srx = b;
    wait_ticks(16);
  endtask

  task automatic send_frame(input int nbits, input logic [7:0] data, input logic pen,
                            input logic pbit, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) send_bit(data[i]);
    if (pen) send_bit(pbit);
    send_bit(stop);
    srx = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  dbits;
    logic        pen;
    logic        peven;
    logic        pstick;
    logic [7:0]  data;
    logic        pbit;
    logic        stop;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[13];

  initial begin
    // Record = {data, break, parity_err, framing_err}.
    vecs[0]  = '{2'd3, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 11'h528}; // 8N1
    vecs[1]  = '{2'd2, 1'b1, 1'b1, 1'b0, 8'h35, 1'b1, 1'b1, 11'h1AA}; // 7E1 bad parity
    vecs[2]  = '{2'd0, 1'b0, 1'b0, 1'b0, 8'h1F, 1'b0, 1'b0, 11'h0F9}; // 5N1 framing
    vecs[3]  = '{2'd3, 1'b0, 1'b0, 1'b0, 8'h41, 1'b0, 1'b1, 11'h208}; // 8N1
    vecs[4]  = '{2'd3, 1'b1, 1'b1, 1'b0, 8'h0F, 1'b0, 1'b1, 11'h078}; // 8E1 good parity
    vecs[5]  = '{2'd1, 1'b1, 1'b0, 1'b0, 8'h2A, 1'b0, 1'b1, 11'h150}; // 6O1 good parity
    vecs[6]  = '{2'd1, 1'b1, 1'b0, 1'b0, 8'h2A, 1'b1, 1'b1, 11'h152}; // 6O1 bad parity
    vecs[7]  = '{2'd3, 1'b1, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1, 11'h3FA}; // stick: expects 0
    vecs[8]  = '{2'd2, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 11'h008}; // stick: expects 1
    vecs[9]  = '{2'd0, 1'b0, 1'b0, 1'b0, 8'hE3, 1'b0, 1'b1, 11'h018}; // 5N1, upper bits 0
    vecs[10] = '{2'd2, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 11'h005}; // 7E1 break
    vecs[11] = '{2'd3, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 11'h001}; // parity 1: no break
    vecs[12] = '{2'd3, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 11'h000}; // 8N1 zero data
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int base;

    nreset       = 1'b0;
    srx          = 1'b1;
    rx_reset     = 1'b0;
    data_bits    = 2'd3;
    parity_en    = 1'b0;
    parity_even  = 1'b0;
    parity_stick = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset_record", {21'd0, record}, 32'h0);
    check("reset_push", {31'd0, push}, 32'h0);
    check("reset_busy", {31'd0, busy}, 32'h0);
    nreset = 1'b1;
    wait_ticks(4);
    check("idle_busy", {31'd0, busy}, 32'h0);

    // Table-driven frames.
    for (int i = 0; i < 13; i++) begin
      data_bits    = vecs[i].dbits;
      parity_en    = vecs[i].pen;
      parity_even  = vecs[i].peven;
      parity_stick = vecs[i].pstick;
      base = push_cnt;
      exp_q.push_back(vecs[i].exp);
      send_frame(5 + int'(vecs[i].dbits), vecs[i].data, vecs[i].pen, vecs[i].pbit, vecs[i].stop);
      wait_ticks(24);
      check($sformatf("v%0d_busy", i), {31'd0, busy}, 32'h0);
      score($sformatf("v%0d", i), base, 1);
    end

    // Line held low for three 8N1 frame times: one break record, then silence.
    data_bits = 2'd3; parity_en = 1'b0; parity_even = 1'b0; parity_stick = 1'b0;
    base = push_cnt;
    exp_q.push_back(11'h005);
    srx = 1'b0;
    wait_ticks(3 * 10 * 16);
    check("break_held_pushes", push_cnt - base, 1);
    check("break_held_busy", {31'd0, busy}, 32'h1);
    srx = 1'b1;
    wait_ticks(24);
    check("break_release_busy", {31'd0, busy}, 32'h0);
    score("break", base, 1);
    base = push_cnt;
    exp_q.push_back(11'h208);
    send_frame(8, 8'h41, 1'b0, 1'b0, 1'b1);
    wait_ticks(24);
    score("after_break", base, 1);

    // Four-tick low glitch on the idle line.
    base = push_cnt;
    srx = 1'b0;
    wait_ticks(4);
    check("glitch_busy_hi", {31'd0, busy}, 32'h1);
    srx = 1'b1;
    wait_ticks(12);
    check("glitch_busy_lo", {31'd0, busy}, 32'h0);
    wait_ticks(40);
    score("glitch", base, 0);

    // rx_reset in the middle of data bit 3 of 0x55, then a clean 0x3C.
    base = push_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(((8'h55 >> i) & 8'h01) != 0);
    srx = 1'b0;
    wait_ticks(8);
    check("rxrst_busy_before", {31'd0, busy}, 32'h1);
    rx_reset = 1'b1;
    @(posedge clk);
    #1;
    rx_reset = 1'b0;
    srx = 1'b1;
    check("rxrst_busy", {31'd0, busy}, 32'h0);
    check("rxrst_push", {31'd0, push}, 32'h0);
    check("rxrst_record", {21'd0, record}, 32'h0);
    wait_ticks(200);
    score("rxrst_discard", base, 0);
    base = push_cnt;
    exp_q.push_back(11'h1E0);
    send_frame(8, 8'h3C, 1'b0, 1'b0, 1'b1);
    wait_ticks(24);
    score("after_rxrst", base, 1);

    // Asynchronous nreset mid-frame takes effect without a clock edge.
    base = push_cnt;
    srx = 1'b0;
    wait_ticks(20);
    check("nrst_busy_before", {31'd0, busy}, 32'h1);
    #2;
    nreset = 1'b0;
    #1;
    check("nrst_push", {31'd0, push}, 32'h0);
    check("nrst_busy", {31'd0, busy}, 32'h0);
    check("nrst_record", {21'd0, record}, 32'h0);
    srx = 1'b1;
    #20;
    nreset = 1'b1;
    wait_ticks(24);
    score("nrst_discard", base, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
